// File: rtl/bn_pkg.sv
// Shared state encoding, default geometry and cfg_data field layout for the
// batch-norm parameter sequencer.
package bn_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2
  } state_e;

  localparam int NO_CH_DEF     = 10;
  localparam int AB_BW_DEF     = 5;
  localparam int BW_IN_DEF     = 12;
  localparam int FRAME_LEN_DEF = 128;

  function automatic int cfg_width(input int ab_bw, input int bw_in);
    return 2 * ab_bw + 2 * bw_in;
  endfunction

  localparam int CFG_W = cfg_width(AB_BW_DEF, BW_IN_DEF);

  // cfg_data = {x_max, x_min, b, a} with a at the LSBs
  function automatic int off_a();
    return 0;
  endfunction

  function automatic int off_b(input int ab_bw);
    return ab_bw;
  endfunction

  function automatic int off_x_min(input int ab_bw);
    return 2 * ab_bw;
  endfunction

  function automatic int off_x_max(input int ab_bw, input int bw_in);
    return 2 * ab_bw + bw_in;
  endfunction

endpackage

// File: rtl/bn_param_bank.sv
// Shadow/active parameter register file: one shadow channel written per cfg word,
// whole shadow copied into the active bank on swap_i (visible the next cycle).
module bn_param_bank
  import bn_pkg::*;
#(
  parameter  int NO_CH = NO_CH_DEF,
  parameter  int AB_BW = AB_BW_DEF,
  parameter  int BW_IN = BW_IN_DEF,
  localparam int CHW   = (NO_CH > 1) ? $clog2(NO_CH) : 1,
  localparam int CW    = cfg_width(AB_BW, BW_IN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [CHW-1:0]         wr_ch_i,
  input  logic [CW-1:0]          wr_word_i,
  input  logic                   swap_i,
  output logic [NO_CH*AB_BW-1:0] act_a_o,
  output logic [NO_CH*AB_BW-1:0] act_b_o,
  output logic [NO_CH*BW_IN-1:0] act_x_min_o,
  output logic [NO_CH*BW_IN-1:0] act_x_max_o
);

  localparam int OA  = off_a();
  localparam int OB  = off_b(AB_BW);
  localparam int OXL = off_x_min(AB_BW);
  localparam int OXH = off_x_max(AB_BW, BW_IN);

  logic [NO_CH*AB_BW-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  logic [NO_CH*BW_IN-1:0] sh_xl_q, sh_xl_d, sh_xh_q, sh_xh_d;
  logic [NO_CH*AB_BW-1:0] act_a_q, act_a_d, act_b_q, act_b_d;
  logic [NO_CH*BW_IN-1:0] act_xl_q, act_xl_d, act_xh_q, act_xh_d;

  always_comb begin
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    sh_xl_d  = sh_xl_q;
    sh_xh_d  = sh_xh_q;
    act_a_d  = act_a_q;
    act_b_d  = act_b_q;
    act_xl_d = act_xl_q;
    act_xh_d = act_xh_q;
    if (wr_en_i) begin
      sh_a_d[wr_ch_i*AB_BW +: AB_BW]  = wr_word_i[OA +: AB_BW];
      sh_b_d[wr_ch_i*AB_BW +: AB_BW]  = wr_word_i[OB +: AB_BW];
      sh_xl_d[wr_ch_i*BW_IN +: BW_IN] = wr_word_i[OXL +: BW_IN];
      sh_xh_d[wr_ch_i*BW_IN +: BW_IN] = wr_word_i[OXH +: BW_IN];
    end
    // The FSM never writes and swaps in the same cycle, so the old shadow is the full set.
    if (swap_i) begin
      act_a_d  = sh_a_q;
      act_b_d  = sh_b_q;
      act_xl_d = sh_xl_q;
      act_xh_d = sh_xh_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_xl_q  <= '0;
      sh_xh_q  <= '0;
      act_a_q  <= '0;
      act_b_q  <= '0;
      act_xl_q <= '0;
      act_xh_q <= '0;
    end else begin
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_xl_q  <= sh_xl_d;
      sh_xh_q  <= sh_xh_d;
      act_a_q  <= act_a_d;
      act_b_q  <= act_b_d;
      act_xl_q <= act_xl_d;
      act_xh_q <= act_xh_d;
    end
  end

  assign act_a_o     = act_a_q;
  assign act_b_o     = act_b_q;
  assign act_x_min_o = act_xl_q;
  assign act_x_max_o = act_xh_q;

endmodule

// File: rtl/bn_param_sched.sv
// Loads per-channel BN/ReLU/quant parameters into a shadow bank and swaps them in only at
// an activation frame boundary; vectors pass through combinationally, gated by in_rdy.
module bn_param_sched
  import bn_pkg::*;
#(
  parameter int NO_CH     = NO_CH_DEF,
  parameter int AB_BW     = AB_BW_DEF,
  parameter int BW_IN     = BW_IN_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_vld,
  output logic                               cfg_rdy,
  input  logic                               cfg_last,
  input  logic [cfg_width(AB_BW, BW_IN)-1:0] cfg_data,
  input  logic                               in_vld,
  output logic                               in_rdy,
  input  logic [NO_CH*BW_IN-1:0]             in_data,
  output logic                               bn_vld,
  output logic [NO_CH*BW_IN-1:0]             bn_data,
  output logic [NO_CH*AB_BW-1:0]             bn_a,
  output logic [NO_CH*AB_BW-1:0]             bn_b,
  output logic [NO_CH*BW_IN-1:0]             bn_x_min,
  output logic [NO_CH*BW_IN-1:0]             bn_x_max,
  output logic                               frame_done,
  output logic                               cfg_err
);

  localparam int CHW = (NO_CH > 1) ? $clog2(NO_CH) : 1;
  localparam int FCW = $clog2(FRAME_LEN);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(NO_CH - 1);
  localparam logic [FCW-1:0] LAST_POS = FCW'(FRAME_LEN - 1);

  state_e         state_q, state_d;
  logic [CHW-1:0] ch_cnt_q, ch_cnt_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           frame_done_q, frame_done_d;
  logic           cfg_err_q, cfg_err_d;
  logic           cfg_acc, in_acc, swap, last_ch;

  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    cfg_err_d    = cfg_err_q;
    cfg_rdy      = 1'b0;
    in_rdy       = 1'b0;
    swap         = 1'b0;
    last_ch      = (ch_cnt_q == LAST_CH);

    unique case (state_q)
      EMPTY: cfg_rdy = 1'b1;
      RUN: begin
        cfg_rdy = 1'b1;
        in_rdy  = 1'b1;
      end
      PEND: begin
        // Swap cycle is a one-vector bubble so no vector sees a half-updated bank.
        swap   = (frame_cnt_q == '0);
        in_rdy = !swap;
        if (swap) state_d = RUN;
      end
      default: state_d = EMPTY;
    endcase

    cfg_acc = cfg_vld && cfg_rdy;
    in_acc  = in_vld && in_rdy;

    if (cfg_acc) begin
      if (cfg_last && last_ch) begin
        ch_cnt_d = '0;
        state_d  = PEND;
      end else if (cfg_last || last_ch) begin
        ch_cnt_d  = '0;
        cfg_err_d = 1'b1;
      end else begin
        ch_cnt_d = ch_cnt_q + 1'b1;
      end
    end

    if (in_acc) begin
      frame_done_d = (frame_cnt_q == LAST_POS);
      frame_cnt_d  = (frame_cnt_q == LAST_POS) ? '0 : frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      ch_cnt_q     <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  bn_param_bank #(
    .NO_CH (NO_CH),
    .AB_BW (AB_BW),
    .BW_IN (BW_IN)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (cfg_acc),
    .wr_ch_i     (ch_cnt_q),
    .wr_word_i   (cfg_data),
    .swap_i      (swap),
    .act_a_o     (bn_a),
    .act_b_o     (bn_b),
    .act_x_min_o (bn_x_min),
    .act_x_max_o (bn_x_max)
  );

  assign bn_vld     = in_acc;
  assign bn_data    = in_data;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/bn_param_sched.md
Name: bn_param_sched

Overview:
- Sequences per-channel batch-norm/ReLU/quantize parameters (a, b, x_min, x_max) into the bn_relu_quantize datapath.
- Parameters arrive as a serial configuration stream and are written into a shadow bank.
- The shadow bank is swapped into the active bank only at a frame boundary of the activation stream, so each frame sees one consistent parameter set.
- Sits between the layer-config source and the bn_relu_quantize instance; gates the activation stream until parameters are valid.

Parameters:
NO_CH, 10, channels per activation vector
AB_BW, 5, width of a and b
BW_IN, 12, width of activation and of x_min/x_max
FRAME_LEN, 128, activation vectors per frame (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
cfg_vld  input  1  config word valid
cfg_rdy  output  1  config word accepted when cfg_vld&&cfg_rdy
cfg_last  input  1  marks final word of a parameter set
cfg_data  input  2*AB_BW+2*BW_IN  packed {x_max, x_min, b, a}, a at LSBs
in_vld  input  1  activation vector valid
in_rdy  output  1  activation vector accepted when in_vld&&in_rdy
in_data  input  NO_CH*BW_IN  activation vector
bn_vld  output  1  to datapath vld_in = in_vld&&in_rdy
bn_data  output  NO_CH*BW_IN  to datapath data_in = in_data (combinational)
bn_a, bn_b  output  NO_CH*AB_BW  active-bank a, b
bn_x_min, bn_x_max  output  NO_CH*BW_IN  active-bank thresholds
frame_done  output  1  one-cycle pulse after last vector of a frame is accepted
cfg_err  output  1  sticky cfg_last framing error

Behaviour:
- Reset (async assert, sync to clk on release): state EMPTY, ch_cnt=0, frame_cnt=0, both banks 0, frame_done=0, cfg_err=0.
- Combinational outputs after reset: cfg_rdy=1, in_rdy=0.
- States:
  - EMPTY: no valid active bank.
  - RUN: active bank valid, shadow loading or idle.
  - PEND: shadow full, awaiting a boundary.
- Config load (EMPTY or RUN): cfg_rdy=1.
  - Each accepted word is written to shadow[ch_cnt], then ch_cnt increments.
  - Word for ch_cnt==NO_CH-1 with cfg_last=1: shadow complete, ch_cnt->0, go to PEND.
  - cfg_last mismatch (cfg_last=1 with ch_cnt<NO_CH-1, or cfg_last=0 with ch_cnt==NO_CH-1): set cfg_err, discard the partial shadow (ch_cnt->0), stay in the current state. The active bank is unaffected.
- PEND: cfg_rdy=0.
  - Swap condition: frame_cnt==0. On that edge, active<=shadow and state->RUN.
  - In that same cycle in_rdy=0 (one bubble), so no vector ever straddles a swap.
- in_rdy = (state==RUN) || (state==PEND && frame_cnt!=0).
- Each accepted vector increments frame_cnt, wrapping FRAME_LEN-1 -> 0.
  - frame_done is registered: asserted the cycle after the vector at frame_cnt==FRAME_LEN-1 is accepted.
- EMPTY->PEND->RUN: swap occurs on the cycle after completion, since frame_cnt==0.
- Datapath latency is 2 and it samples parameters only in its first stage. The active bank is therefore held stable for every accepted vector; parameter changes take effect from the first vector after the swap.
- Simultaneous config word and vector accept in RUN: both proceed independently.
- Reset mid-load or mid-frame: all state discarded, returns to EMPTY.
- cfg_err clears only on rst.

Decomposition:
- Package bn_pkg:
  - state enum {EMPTY, RUN, PEND}
  - CFG_W localparam function of AB_BW, BW_IN
  - field offset constants for cfg_data unpacking
- One sub-module, bn_param_bank: shadow + active register file with write port (ch, word) and swap strobe. The FSM and counters stay in bn_param_sched.

Test Plan:
- Load set A (a[i]=i+1, b[i]=2, x_min=-4, x_max=100, cfg_last on word 9) with in_vld=1 → in_rdy=0 until one cycle after word 9 is accepted; then bn_a[3]=4 and bn_vld follows in_vld.
- With set A active, stream vectors and load set B (a=7) mid-frame after 10 vectors → PEND.
  - cfg_rdy=0; bn_a unchanged for vectors 10..127.
  - frame_done pulses after vector 127.
  - One in_rdy bubble, then bn_a[i]=7 for vector 0 of the next frame.
- cfg_last on word 4 → cfg_err=1, ch_cnt reset.
  - A subsequent correct 10-word set loads normally; cfg_err stays 1.
- Hold cfg_vld=1 continuously while PEND → no words accepted until the swap; ch_cnt starts at 0 for the next set.
- Assert rst while set B is half-loaded and frame_cnt=50 → immediately cfg_rdy=1, in_rdy=0, banks 0, cfg_err=0.
- Random cfg_vld/in_vld backpressure, 3 sets, FRAME_LEN=4 → scoreboard checks every bn_vld vector sees exactly the bank active at its frame start.
